// File: rtl/stepper_phase_if.sv
// -----------------------------------------------------------------------------
// stepper_phase_if
//   Bundles the coil phase input, the clear strobe and the decoded monitor
//   outputs of stepper_phase_decoder.
//
//   Signals
//     phase_in   [3:0]    coil phase bus (one-hot P0..P3, 0000 = off)
//     clr                 synchronous clear of position, step_count and fault
//     position   [POS_W]  signed step position (two's complement, wraps)
//     step_count [CNT_W]  total accepted steps (saturating)
//     step_pulse          one-cycle strobe per accepted step
//     dir_out             1 = forward (P0->P1->P2->P3), 0 = reverse
//     state_out  [1:0]    00 OFF, 01 HOLD, 10 RUN
//     fault               sticky fault flag
//     fault_code [1:0]    00 none, 01 skip, 10 multi-hot (first fault only)
//
//   Modports
//     master : stimulus side, drives phase_in/clr and observes the outputs
//     slave  : the decoder
// -----------------------------------------------------------------------------
interface stepper_phase_if #(
    parameter int POS_W = 16,
    parameter int CNT_W = 16
);
    logic [3:0]              phase_in;
    logic                    clr;
    logic signed [POS_W-1:0] position;
    logic [CNT_W-1:0]        step_count;
    logic                    step_pulse;
    logic                    dir_out;
    logic [1:0]              state_out;
    logic                    fault;
    logic [1:0]              fault_code;

    modport master (
        output phase_in, clr,
        input  position, step_count, step_pulse, dir_out,
               state_out, fault, fault_code
    );

    modport slave (
        input  phase_in, clr,
        output position, step_count, step_pulse, dir_out,
               state_out, fault, fault_code
    );
endinterface

// File: rtl/stepper_phase_decoder.sv
// -----------------------------------------------------------------------------
// stepper_phase_decoder
//   Receive-side monitor for a stepper motor coil phase bus. Synchronizes the
//   4-bit one-hot phase bus, recovers step events, direction, signed position
//   and motion state (OFF/HOLD/RUN), and flags illegal phase sequences (a
//   two-position skip or a multi-hot phase word).
//
//   Ports
//     clk_25  in   block clock, rising edge
//     rst     in   asynchronous, active-high reset
//     bus     slave modport of stepper_phase_if:
//               phase_in (asynchronous to clk_25), clr in;
//               position, step_count, step_pulse, dir_out, state_out,
//               fault, fault_code out (all registered)
//
//   Latency: a phase change captured by the first synchronizer flop at edge k
//   appears on the outputs after edge k+2. Each phase must be held for at
//   least 3 clk_25 cycles to be decoded.
// -----------------------------------------------------------------------------
module stepper_phase_decoder #(
    parameter int POS_W   = 16,
    parameter int CNT_W   = 16,
    parameter int IDLE_TO = 8
) (
    input  logic            clk_25,
    input  logic            rst,
    stepper_phase_if.slave  bus
);

    localparam int IDLE_W = $clog2(IDLE_TO + 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_HOLD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE  = 2'b00,
        FC_SKIP  = 2'b01,
        FC_MULTI = 2'b10
    } fault_code_t;

    // ---------------------------------------------------------------------
    // Input synchronizer
    // ---------------------------------------------------------------------
    logic [3:0] s1;
    logic [3:0] s2;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which is what makes the
    // s1 -> s2 chain a two-stage pipeline rather than a single wire.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            s1 <= 4'b0000;
            s2 <= 4'b0000;
        end else begin
            s1 <= bus.phase_in;
            s2 <= s1;
        end
    end

    // ---------------------------------------------------------------------
    // Phase decode
    // ---------------------------------------------------------------------
    logic       is_off;
    logic       is_onehot;
    logic [1:0] idx;

    assign is_off    = (s2 == 4'b0000);
    assign is_onehot = $onehot(s2);

    always_comb begin
        unique case (s2)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Tracking state
    // ---------------------------------------------------------------------
    state_t             state,      state_nxt;
    logic               prev_valid, prev_valid_nxt;
    logic [1:0]         prev_idx,   prev_idx_nxt;
    logic [IDLE_W-1:0]  idle_cnt,   idle_nxt;

    logic               step_fwd;
    logic               step_rev;
    logic               new_fault;
    fault_code_t        new_code;
    logic [1:0]         delta;

    // Modular distance from the previous phase: 1 = forward, 3 = reverse,
    // 2 = skip, 0 = unchanged.
    assign delta = idx - prev_idx;

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state      <= ST_OFF;
            prev_valid <= 1'b0;
            prev_idx   <= 2'd0;
            idle_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            prev_valid <= prev_valid_nxt;
            prev_idx   <= prev_idx_nxt;
            idle_cnt   <= idle_nxt;
        end
    end

    // NOTE: every output of this block gets a default before any branch so
    // that no path leaves a variable unassigned and infers a latch.
    always_comb begin
        state_nxt      = state;
        prev_valid_nxt = prev_valid;
        prev_idx_nxt   = prev_idx;
        idle_nxt       = idle_cnt;
        step_fwd       = 1'b0;
        step_rev       = 1'b0;
        new_fault      = 1'b0;
        new_code       = FC_NONE;

        if (is_off) begin
            prev_valid_nxt = 1'b0;
            state_nxt      = ST_OFF;
            idle_nxt       = '0;
        end else if (!is_onehot) begin
            // Multi-hot: record the fault, leave tracking untouched.
            new_fault = 1'b1;
            new_code  = FC_MULTI;
        end else if (!prev_valid) begin
            // First energized phase only establishes the reference.
            prev_valid_nxt = 1'b1;
            prev_idx_nxt   = idx;
            state_nxt      = ST_HOLD;
            idle_nxt       = '0;
        end else begin
            unique case (delta)
                2'd0: begin
                    if (idle_cnt != IDLE_W'(IDLE_TO)) begin
                        idle_nxt = idle_cnt + IDLE_W'(1);
                    end
                    if (state == ST_RUN && idle_nxt == IDLE_W'(IDLE_TO)) begin
                        state_nxt = ST_HOLD;
                    end
                end
                2'd1, 2'd3: begin
                    step_fwd     = (delta == 2'd1);
                    step_rev     = (delta == 2'd3);
                    prev_idx_nxt = idx;
                    idle_nxt     = '0;
                    state_nxt    = ST_RUN;
                end
                default: begin
                    // Jump of two positions: direction is ambiguous, so
                    // resynchronize on the new phase without counting.
                    prev_idx_nxt = idx;
                    new_fault    = 1'b1;
                    new_code     = FC_SKIP;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Registered outputs
    // ---------------------------------------------------------------------
    logic [POS_W-1:0] position_q;
    logic [CNT_W-1:0] step_count_q;
    logic             step_pulse_q;
    logic             dir_q;
    logic             fault_q;
    fault_code_t      fault_code_q;

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            position_q   <= '0;
            step_count_q <= '0;
            step_pulse_q <= 1'b0;
            dir_q        <= 1'b0;
        end else begin
            // The pulse and direction follow the decode even when clr drops
            // the step from the counters.
            step_pulse_q <= step_fwd | step_rev;
            if (step_fwd) begin
                dir_q <= 1'b1;
            end else if (step_rev) begin
                dir_q <= 1'b0;
            end

            if (bus.clr) begin
                position_q   <= '0;
                step_count_q <= '0;
            end else if (step_fwd || step_rev) begin
                position_q <= step_fwd ? position_q + POS_W'(1)
                                       : position_q - POS_W'(1);
                if (step_count_q != '1) begin
                    step_count_q <= step_count_q + CNT_W'(1);
                end
            end
        end
    end

    // First fault wins until clr; a fault arriving together with clr is kept
    // (set-dominant) with its own code.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else if (new_fault && (!fault_q || bus.clr)) begin
            fault_q      <= 1'b1;
            fault_code_q <= new_code;
        end else if (bus.clr) begin
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end
    end

    assign bus.position   = position_q;
    assign bus.step_count = step_count_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.dir_out    = dir_q;
    assign bus.state_out  = state;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;

endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
- Receive-side counterpart of the stepper motor driver: samples the 4-bit one-hot coil phase bus and recovers step events, direction, signed position and motion state.
- Flags phase sequences the driver must never produce.
- Sits beside the motor path as a position and health monitor; outputs feed the display and control logic.

Parameters:
POS_W, 16, width of signed position counter (two's complement, wraps)
CNT_W, 16, width of unsigned total-step counter (saturates)
IDLE_TO, 8, clk_25 cycles without a step, while energized, before RUN falls back to HOLD (>=1)

Ports:
clk_25  input  1  block clock, rising edge
rst  input  1  asynchronous, active-high reset
phase_in  input  4  coil phase bus: 0001=P0, 0010=P1, 0100=P2, 1000=P3, 0000=off; asynchronous to clk_25
clr  input  1  synchronous clear of position, step_count and fault
position  output  POS_W  signed step position
step_count  output  CNT_W  total accepted steps, saturating
step_pulse  output  1  one-cycle strobe per accepted step
dir_out  output  1  direction of last accepted step: 1 = P0->P1->P2->P3, 0 = reverse
state_out  output  2  00 OFF, 01 HOLD, 10 RUN
fault  output  1  sticky fault flag
fault_code  output  2  00 none, 01 skip (phase jumped by 2), 10 multi-hot phase; holds first fault

Behaviour:
- Reset: all outputs 0; state_out=OFF; synchronizer and previous-phase register cleared to "none"; idle counter 0.
- Input path:
  - phase_in passes through a 2-flop synchronizer (s1, s2).
  - Decode compares s2 against the previous-phase register prev (index 0..3 or none).
  - All outputs are registered.
  - Latency: a phase change captured at edge k is visible on the outputs after edge k+2.
  - The source must hold each phase for >=3 clk_25 cycles; faster sequences are out of spec and not detected.
- Decode rules, per cycle, on s2:
  - 0000: prev<=none; state OFF; idle counter cleared; no step.
  - Valid one-hot, prev=none: prev<=index; state HOLD; no step. The first energized phase is not a step.
  - Same as prev: no step; idle counter increments, saturating at IDLE_TO.
  - index = prev+1 mod 4: forward step. position+1, dir_out<=1.
  - index = prev-1 mod 4: reverse step. position-1, dir_out<=0.
  - On either accepted step: step_pulse=1 for one cycle; step_count+1 (saturates at all ones); prev<=index; idle counter<=0; state RUN.
  - index = prev+2 mod 4: skip fault. No step; position unchanged; prev<=index.
  - Multi-hot (two or more bits set): multi-hot fault. No step; prev unchanged; state unchanged.
- Fault recording: fault is set on the first fault. fault_code latches that first code and is not overwritten by later faults until clr.
- State machine:
  - OFF -> HOLD on first valid phase.
  - HOLD -> RUN on accepted step.
  - RUN -> HOLD when the idle counter reaches IDLE_TO.
  - HOLD/RUN -> OFF on 0000.
  - RUN stays RUN while steps arrive at less than IDLE_TO spacing.
- Position arithmetic: modular POS_W-bit. 0x7FFF+1 -> 0x8000; 0x0000-1 -> 0xFFFF.
- clr:
  - Synchronous. Next cycle position=0, step_count=0, fault=0, fault_code=00.
  - Does not affect prev, state_out or dir_out.
  - clr and an accepted step in the same cycle: clr wins for the counters (step dropped), but step_pulse still fires and prev/dir update.
  - clr and a new fault in the same cycle: the fault is set (set-dominant), with its code.
- Reset mid-sequence: immediate return to reset values. The first valid phase after reset is treated as the initial phase, not a step.

Test Plan:
- Reset, then phase_in 0000->0001->0010->0100->1000->0001, each held 4 cycles -> 4 step_pulses; position=4; step_count=4; dir_out=1; state HOLD->RUN; fault=0.
- From position 4, sequence 0001->1000->0100->0010 -> 3 pulses; position=1; dir_out=0; step_count=7.
- Hold 0010 for 10 cycles after a step with IDLE_TO=8 -> state_out RUN->HOLD exactly 8 cycles after the step decode. Then drive 0000 -> state_out=OFF, no pulse.
- Drive 0001 then 0100 -> no pulse, fault=1, fault_code=01. Then drive 0011 -> fault_code stays 01. clr pulse -> fault=0, code=00, position=0.
- Preload position to 0x7FFF via 32767 forward steps (or POS_W=4 build: 7 steps), then one more forward step -> position wraps to 0x8000 (0x8). One reverse step -> back to max positive.
- Assert rst asynchronously mid-RUN (position=5) -> outputs 0 immediately. Next phase 0100 -> HOLD, no pulse. Following 1000 -> position=1.
